// File: rtl/ex_mem_if.sv
// EX->MEM stage bus: upstream ALU beat, downstream MEM beat and the branch redirect.
interface ex_mem_if #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned REG_ADDR_W = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [XLEN-1:0]       in_alu_result;
    logic                  in_zero;
    logic [XLEN-1:0]       in_store_data;
    logic [REG_ADDR_W-1:0] in_rd;
    logic [3:0]            in_ctrl;
    logic                  in_branch;
    logic [XLEN-1:0]       in_br_target;

    logic                  out_valid;
    logic                  out_ready;
    logic [XLEN-1:0]       out_alu_result;
    logic                  out_zero;
    logic [XLEN-1:0]       out_store_data;
    logic [REG_ADDR_W-1:0] out_rd;
    logic [3:0]            out_ctrl;
    logic                  pc_src;
    logic [XLEN-1:0]       pc_target;

    modport master (
        output in_valid, in_alu_result, in_zero, in_store_data, in_rd,
               in_ctrl, in_branch, in_br_target, out_ready,
        input  in_ready, out_valid, out_alu_result, out_zero, out_store_data,
               out_rd, out_ctrl, pc_src, pc_target
    );

    modport slave (
        input  in_valid, in_alu_result, in_zero, in_store_data, in_rd,
               in_ctrl, in_branch, in_br_target, out_ready,
        output in_ready, out_valid, out_alu_result, out_zero, out_store_data,
               out_rd, out_ctrl, pc_src, pc_target
    );
endinterface

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with main+skid buffering, branch resolution and PC redirect.
module ex_mem_stage #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     flush,
    ex_mem_if.slave  bus
);
    localparam int unsigned CTRL_W = 4;

    typedef struct packed {
        logic [XLEN-1:0]       alu_result;
        logic                  zero;
        logic [XLEN-1:0]       store_data;
        logic [REG_ADDR_W-1:0] rd;
        logic [CTRL_W-1:0]     ctrl;
        logic                  taken;
        logic [XLEN-1:0]       br_target;
    } beat_t;

    // Occupancy: nothing, main only, main + skid.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_MAIN  = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t r_state, w_state_nxt;
    beat_t  r_main, r_skid, w_main_nxt, w_skid_nxt, w_in_beat;
    logic   r_in_ready;
    logic   w_main_v, w_accept, w_emit;

    always_comb begin
        w_in_beat            = '0;
        w_in_beat.alu_result = bus.in_alu_result;
        w_in_beat.zero       = bus.in_zero;
        w_in_beat.store_data = bus.in_store_data;
        w_in_beat.rd         = bus.in_rd;
        w_in_beat.ctrl       = bus.in_ctrl;
        w_in_beat.taken      = bus.in_branch & bus.in_zero;
        w_in_beat.br_target  = bus.in_br_target;
    end

    assign w_main_v = (r_state != S_EMPTY);
    assign w_accept = bus.in_valid & r_in_ready;
    assign w_emit   = w_main_v & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_EMPTY;
            r_main     <= '0;
            r_skid     <= '0;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_main     <= w_main_nxt;
            r_skid     <= w_skid_nxt;
            r_in_ready <= (w_state_nxt != S_FULL);
        end
    end

    // Flush takes priority over any same-cycle accept; payload regs keep stale data.
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            unique case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        w_main_nxt  = w_in_beat;
                        w_state_nxt = S_MAIN;
                    end
                end
                S_MAIN: begin
                    if (w_emit && w_accept) begin
                        w_main_nxt = w_in_beat;
                    end else if (w_emit) begin
                        w_state_nxt = S_EMPTY;
                    end else if (w_accept) begin
                        w_skid_nxt  = w_in_beat;
                        w_state_nxt = S_FULL;
                    end
                end
                S_FULL: begin
                    if (w_emit) begin
                        w_main_nxt  = r_skid;
                        w_state_nxt = S_MAIN;
                    end
                end
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    assign bus.in_ready       = r_in_ready;
    assign bus.out_valid      = w_main_v;
    assign bus.out_alu_result = r_main.alu_result;
    assign bus.out_zero       = r_main.zero;
    assign bus.out_store_data = r_main.store_data;
    assign bus.out_rd         = r_main.rd;
    assign bus.out_ctrl       = r_main.ctrl & {CTRL_W{w_main_v}};
    assign bus.pc_src         = w_main_v & r_main.taken;
    assign bus.pc_target      = r_main.br_target;
endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: directed beats queued on accept, monitor checks on emit.
module tb_ex_mem_stage;
    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    typedef struct {
        logic [63:0] alu;
        logic        zero;
        logic [63:0] st;
        logic [4:0]  rd;
        logic [3:0]  ctrl;
        logic        pc_src;
        logic [63:0] tgt;
        int          lat;
    } exp_t;

    exp_t q[$];

    ex_mem_if #(.XLEN(64), .REG_ADDR_W(5)) bus ();

    ex_mem_stage #(.XLEN(64), .REG_ADDR_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Hold a beat on the input until accepted; queue its expected output at the accepting edge.
    task automatic send(input logic [63:0] alu, input logic zero, input logic [63:0] st,
                        input logic [4:0] rd, input logic [3:0] ctrl, input logic br,
                        input logic [63:0] tgt, input bit lat_chk);
        exp_t e;
        bit   done = 1'b0;
        bus.in_valid      = 1'b1;
        bus.in_alu_result = alu;
        bus.in_zero       = zero;
        bus.in_store_data = st;
        bus.in_rd         = rd;
        bus.in_ctrl       = ctrl;
        bus.in_branch     = br;
        bus.in_br_target  = tgt;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                e.alu = alu; e.zero = zero; e.st = st; e.rd = rd; e.ctrl = ctrl;
                e.pc_src = br & zero; e.tgt = tgt;
                e.lat = lat_chk ? cyc + 1 : -1;
                q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        chk("send_accepted", 64'(done), 64'd1);
    endtask

    task automatic wait_drain();
        int k = 0;
        while (q.size() != 0 && k < 100) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("drain", 64'(q.size()), 64'd0);
    endtask

    // Monitor: compare every emitted beat against the queue head; bubbles must gate ctrl/pc_src.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=0x%0h required=none", bus.out_alu_result);
                end else begin
                    e = q.pop_front();
                    chk("alu_result", bus.out_alu_result, e.alu);
                    chk("zero", 64'(bus.out_zero), 64'(e.zero));
                    chk("store_data", bus.out_store_data, e.st);
                    chk("rd", 64'(bus.out_rd), 64'(e.rd));
                    chk("ctrl", 64'(bus.out_ctrl), 64'(e.ctrl));
                    chk("pc_src", 64'(bus.pc_src), 64'(e.pc_src));
                    chk("pc_target", bus.pc_target, e.tgt);
                    if (e.lat >= 0) chk("latency", 64'(cyc), 64'(e.lat));
                end
            end else if (!bus.out_valid) begin
                chk("bubble_ctrl", 64'(bus.out_ctrl), 64'd0);
                chk("bubble_pc_src", 64'(bus.pc_src), 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_alu_result = '0; bus.in_zero = 1'b0;
        bus.in_store_data = '0; bus.in_rd = '0; bus.in_ctrl = '0;
        bus.in_branch = 1'b0; bus.in_br_target = '0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_ctrl", 64'(bus.out_ctrl), 64'd0);
        chk("rst_pc_src", 64'(bus.pc_src), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full-rate stream, each beat out one cycle after accept.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(64'h1000_0000_0000_0000 + 64'(i), 1'(i), 64'hA5A5_0000_0000_0000 | 64'(i * 3),
                 5'(i + 1), 4'(i + 1), 1'b0, 64'h0, 1'b1);
        end
        wait_drain();

        // Backpressure: A held in main, B in skid, C waits.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        send(64'h1, 1'b0, 64'h11, 5'd1, 4'b1000, 1'b0, 64'h0, 1'b0);
        send(64'h2, 1'b0, 64'h22, 5'd2, 4'b0100, 1'b0, 64'h0, 1'b0);
        chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        fork
            send(64'h3, 1'b0, 64'h33, 5'd3, 4'b0010, 1'b0, 64'h0, 1'b0);
        join_none
        repeat (3) @(negedge clk);
        chk("bp_in_ready_held", 64'(bus.in_ready), 64'd0);
        chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
        chk("bp_a_held", bus.out_alu_result, 64'h1);
        chk("bp_c_waiting", 64'(q.size()), 64'd2);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_drain();
        repeat (3) @(posedge clk); #1;

        // Branch resolution.
        send(64'h10, 1'b1, 64'h0, 5'd4, 4'b0000, 1'b1, 64'h400, 1'b0);
        send(64'h20, 1'b0, 64'h0, 5'd5, 4'b0000, 1'b1, 64'h800, 1'b0);
        send(64'h30, 1'b1, 64'h0, 5'd6, 4'b1001, 1'b0, 64'hC00, 1'b0);
        wait_drain();

        // Flush with both entries full and a pending beat.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        send(64'hA1, 1'b1, 64'h0, 5'd7, 4'b1111, 1'b1, 64'h123, 1'b0);
        send(64'hA2, 1'b0, 64'h0, 5'd8, 4'b1111, 1'b0, 64'h0, 1'b0);
        bus.in_valid = 1'b1; bus.in_alu_result = 64'hDD; bus.in_ctrl = 4'hF;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; bus.in_valid = 1'b0;
        q.delete();
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
        chk("flush_pc_src", 64'(bus.pc_src), 64'd0);
        // Flush beats a same-cycle accept while the stage is ready.
        bus.in_valid = 1'b1; bus.in_alu_result = 64'hEE; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; bus.in_valid = 1'b0;
        chk("flush_accept_dropped", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk); #1;
        send(64'h55, 1'b0, 64'h66, 5'd9, 4'b1010, 1'b0, 64'h0, 1'b0);
        wait_drain();

        // Bubble gating with garbage on the input.
        bus.in_valid = 1'b0; bus.in_ctrl = 4'b1111; bus.in_branch = 1'b1; bus.in_zero = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("gate_out_ctrl", 64'(bus.out_ctrl), 64'd0);
            chk("gate_out_valid", 64'(bus.out_valid), 64'd0);
        end
        @(posedge clk); #1;

        // Asynchronous reset mid-stream.
        bus.out_ready = 1'b0;
        send(64'h71, 1'b1, 64'h0, 5'd10, 4'b1100, 1'b1, 64'h900, 1'b0);
        send(64'h72, 1'b0, 64'h0, 5'd11, 4'b0011, 1'b0, 64'h0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("async_rst_out_ctrl", 64'(bus.out_ctrl), 64'd0);
        chk("async_rst_pc_src", 64'(bus.pc_src), 64'd0);
        chk("async_rst_in_ready", 64'(bus.in_ready), 64'd1);
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
